// File: rtl/multicycle_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_sequencer_if
// Description : Control bundle between the RV32I multi-cycle sequencer and its
//               datapath / shared memory port.
//               master : sequencer side (drives control, receives status)
//               slave  : datapath side (drives status, receives control)
// Ports (signals):
//   opcode[6:0]     IR[6:0], stable from DECODE until the next FETCH
//   branch_taken    ALU compare result, valid in EXECUTE for BRANCH
//   mem_ack         memory completion, may coincide with mem_req
//   mem_req/mem_we  memory request / store qualifier
//   addr_sel        0 = PC, 1 = ALUOut register
//   ir_we/pc_we     IR / PC load strobes
//   pc_sel[1:0]     00 = PC+4, 01 = ALUOut, 10 = live ALU result
//   reg_we          register-file write strobe
//   wb_sel[1:0]     00 = ALUOut, 01 = memory data, 10 = old PC+4
//   alu_op[1:0]     00 = add, 01 = branch compare, 10 = funct-decoded
//   alu_src_a[1:0]  00 = rs1, 01 = old PC, 10 = zero
//   alu_src_b       0 = rs2, 1 = immediate
//   state[2:0]      current sequencer state (debug)
//   halted          illegal opcode seen
//   instret         retired-instruction count
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_sequencer_if #(
    parameter int INSTRET_WIDTH = 32
);
    logic [6:0]               opcode;
    logic                     branch_taken;
    logic                     mem_ack;
    logic                     mem_req;
    logic                     mem_we;
    logic                     addr_sel;
    logic                     ir_we;
    logic                     pc_we;
    logic [1:0]               pc_sel;
    logic                     reg_we;
    logic [1:0]               wb_sel;
    logic [1:0]               alu_op;
    logic [1:0]               alu_src_a;
    logic                     alu_src_b;
    logic [2:0]               state;
    logic                     halted;
    logic [INSTRET_WIDTH-1:0] instret;

    modport master (
        input  opcode, branch_taken, mem_ack,
        output mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, reg_we,
               wb_sel, alu_op, alu_src_a, alu_src_b, state, halted, instret
    );

    modport slave (
        output opcode, branch_taken, mem_ack,
        input  mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, reg_we,
               wb_sel, alu_op, alu_src_a, alu_src_b, state, halted, instret
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_sequencer
// Description : Multi-cycle FSM sequencing the RV32I datapath through
//               FETCH / DECODE / EXECUTE / MEM / WB, with a retired-instruction
//               counter. Funct fields are refined by the external ALU decoder.
// Ports:
//   clk     : rising-edge clock
//   nreset  : asynchronous active-low reset
//   bus     : multicycle_sequencer_if.master (control / status bundle)
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_sequencer #(
    parameter int INSTRET_WIDTH = 32
) (
    input  wire logic                 clk,
    input  wire logic                 nreset,
    multicycle_sequencer_if.master    bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_HALT    = 3'd7
    } state_t;

    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;

    localparam logic [INSTRET_WIDTH-1:0] c_INSTRET_ONE = {{(INSTRET_WIDTH-1){1'b0}}, 1'b1};

    state_t                   r_state;
    state_t                   w_next;
    logic [INSTRET_WIDTH-1:0] r_instret;
    logic                     w_retire;
    logic                     w_known;

    logic       w_mem_req, w_mem_we, w_addr_sel, w_ir_we, w_pc_we, w_reg_we, w_alu_src_b;
    logic [1:0] w_pc_sel, w_wb_sel, w_alu_op, w_alu_src_a;

    always_comb begin
        w_known = 1'b0;
        case (bus.opcode)
            c_OPC_LOAD, c_OPC_STORE, c_OPC_OP, c_OPC_OPIMM, c_OPC_BRANCH,
            c_OPC_JAL, c_OPC_JALR, c_OPC_LUI, c_OPC_AUIPC: w_known = 1'b1;
            default:                                       w_known = 1'b0;
        endcase
    end

    // State register. Reset is asynchronous so that every output (all decoded
    // from state) collapses to the IDLE values immediately, with no write
    // enable surviving into the reset window.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + c_INSTRET_ONE;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_retire    = 1'b0;
        w_mem_req   = 1'b0;
        w_mem_we    = 1'b0;
        w_addr_sel  = 1'b0;
        w_ir_we     = 1'b0;
        w_pc_we     = 1'b0;
        w_pc_sel    = 2'b00;
        w_reg_we    = 1'b0;
        w_wb_sel    = 2'b00;
        w_alu_op    = 2'b00;
        w_alu_src_a = 2'b00;
        w_alu_src_b = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_next = S_FETCH;
            end
            S_FETCH: begin
                w_mem_req = 1'b1;
                if (bus.mem_ack) begin
                    w_ir_we = 1'b1;
                    w_pc_we = 1'b1;
                    w_next  = S_DECODE;
                end
            end
            S_DECODE: begin
                // ALUOut <= PC_old + imm, the branch/JAL target used in EXECUTE
                w_alu_src_a = 2'b01;
                w_alu_src_b = 1'b1;
                w_next      = w_known ? S_EXECUTE : S_HALT;
            end
            S_EXECUTE: begin
                case (bus.opcode)
                    c_OPC_OP: begin
                        w_alu_op = 2'b10;
                        w_next   = S_WB;
                    end
                    c_OPC_OPIMM: begin
                        w_alu_op    = 2'b10;
                        w_alu_src_b = 1'b1;
                        w_next      = S_WB;
                    end
                    c_OPC_LOAD, c_OPC_STORE: begin
                        w_alu_src_b = 1'b1;
                        w_next      = S_MEM;
                    end
                    c_OPC_BRANCH: begin
                        w_alu_op = 2'b01;
                        w_pc_we  = bus.branch_taken;
                        w_pc_sel = 2'b01;
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
                    end
                    c_OPC_JAL: begin
                        w_pc_we  = 1'b1;
                        w_pc_sel = 2'b01;
                        w_next   = S_WB;
                    end
                    c_OPC_JALR: begin
                        w_alu_src_b = 1'b1;
                        w_pc_we     = 1'b1;
                        w_pc_sel    = 2'b10;
                        w_next      = S_WB;
                    end
                    c_OPC_LUI: begin
                        w_alu_src_a = 2'b10;
                        w_alu_src_b = 1'b1;
                        w_next      = S_WB;
                    end
                    c_OPC_AUIPC: begin
                        w_alu_src_a = 2'b01;
                        w_alu_src_b = 1'b1;
                        w_next      = S_WB;
                    end
                    // IR is stable since DECODE, so this only triggers if the
                    // datapath breaks that contract; treat it as illegal.
                    default: w_next = S_HALT;
                endcase
            end
            S_MEM: begin
                w_mem_req  = 1'b1;
                w_addr_sel = 1'b1;
                w_mem_we   = (bus.opcode == c_OPC_STORE);
                if (bus.mem_ack) begin
                    if (bus.opcode == c_OPC_STORE) begin
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
                    end else begin
                        w_next = S_WB;
                    end
                end
            end
            S_WB: begin
                w_reg_we = 1'b1;
                if (bus.opcode == c_OPC_LOAD) begin
                    w_wb_sel = 2'b01;
                end else if (bus.opcode == c_OPC_JAL || bus.opcode == c_OPC_JALR) begin
                    w_wb_sel = 2'b10;
                end
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign bus.mem_req   = w_mem_req;
    assign bus.mem_we    = w_mem_we;
    assign bus.addr_sel  = w_addr_sel;
    assign bus.ir_we     = w_ir_we;
    assign bus.pc_we     = w_pc_we;
    assign bus.pc_sel    = w_pc_sel;
    assign bus.reg_we    = w_reg_we;
    assign bus.wb_sel    = w_wb_sel;
    assign bus.alu_op    = w_alu_op;
    assign bus.alu_src_a = w_alu_src_a;
    assign bus.alu_src_b = w_alu_src_b;
    assign bus.state     = r_state;
    assign bus.halted    = (r_state == S_HALT);
    assign bus.instret   = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_sequencer
// Description : Directed self-checking bench for multicycle_sequencer, built
//               with a 4-bit retired-instruction counter to exercise wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_sequencer;

    localparam int W = 4;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_ILL    = 7'b0000000;

    logic clk;
    logic nreset;
    int   checks;
    int   failures;

    multicycle_sequencer_if #(.INSTRET_WIDTH(W)) bus ();

    multicycle_sequencer #(.INSTRET_WIDTH(W)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view of every output except instret, in a fixed order:
    // state, mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, reg_we,
    // wb_sel, alu_op, alu_src_a, alu_src_b, halted
    function automatic logic [18:0] ev(input logic [2:0] st, input logic mreq, input logic mwe,
                                       input logic asel, input logic irwe, input logic pcwe,
                                       input logic [1:0] pcsel, input logic regwe,
                                       input logic [1:0] wbsel, input logic [1:0] aluop,
                                       input logic [1:0] srca, input logic srcb, input logic hlt);
        return {st, mreq, mwe, asel, irwe, pcwe, pcsel, regwe, wbsel, aluop, srca, srcb, hlt};
    endfunction

    function automatic logic [18:0] obs();
        return {bus.state, bus.mem_req, bus.mem_we, bus.addr_sel, bus.ir_we, bus.pc_we,
                bus.pc_sel, bus.reg_we, bus.wb_sel, bus.alu_op, bus.alu_src_a,
                bus.alu_src_b, bus.halted};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic chk_out(input string tag, input logic [18:0] e);
        chk(tag, {13'd0, obs()}, {13'd0, e});
    endtask

    task automatic chk_cnt(input string tag, input logic [W-1:0] e);
        chk(tag, {{(32-W){1'b0}}, bus.instret}, {{(32-W){1'b0}}, e});
    endtask

    // Advance to the next falling edge; inputs are then set and outputs
    // sampled 1 time unit later, well clear of the rising edge.
    task automatic nc();
        @(negedge clk);
    endtask

    logic [18:0] V_IDLE, V_FETCH_ACK, V_FETCH_WAIT, V_DECODE, V_HALT;

    initial begin
        checks   = 0;
        failures = 0;
        V_IDLE       = ev(3'd0, 0,0,0, 0,0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        V_FETCH_ACK  = ev(3'd1, 1,0,0, 1,1, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        V_FETCH_WAIT = ev(3'd1, 1,0,0, 0,0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        V_DECODE     = ev(3'd2, 0,0,0, 0,0, 2'b00, 0, 2'b00, 2'b00, 2'b01, 1, 0);
        V_HALT       = ev(3'd7, 0,0,0, 0,0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 1);

        nreset           = 1'b0;
        bus.opcode       = OPC_OP;
        bus.mem_ack      = 1'b1;
        bus.branch_taken = 1'b0;
        nc(); nc(); #1;
        chk_out("reset_outputs", V_IDLE);
        chk_cnt("reset_instret", 4'd0);

        // ---- R-type, zero-wait: 0,1,2,3,5,1 ----
        nc(); nreset = 1'b1; #1;
        chk_out("op_idle", V_IDLE);
        nc(); #1; chk_out("op_fetch", V_FETCH_ACK);
        nc(); #1; chk_out("op_decode", V_DECODE);
        nc(); #1; chk_out("op_execute", ev(3'd3, 0,0,0, 0,0, 2'b00, 0, 2'b00, 2'b10, 2'b00, 0, 0));
        nc(); #1; chk_out("op_wb", ev(3'd5, 0,0,0, 0,0, 2'b00, 1, 2'b00, 2'b00, 2'b00, 0, 0));
        nc(); bus.opcode = OPC_LOAD; #1;
        chk_out("op_next_fetch", V_FETCH_ACK);
        chk_cnt("op_instret", 4'd1);

        // ---- LOAD with two MEM wait cycles ----
        nc(); #1; chk_out("ld_decode", V_DECODE);
        nc(); #1; chk_out("ld_execute", ev(3'd3, 0,0,0, 0,0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 1, 0));
        for (int i = 0; i < 3; i++) begin
            nc(); bus.mem_ack = (i == 2); #1;
            chk_out("ld_mem", ev(3'd4, 1,0,1, 0,0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        end
        nc(); bus.mem_ack = 1'b1; #1;
        chk_out("ld_wb", ev(3'd5, 0,0,0, 0,0, 2'b00, 1, 2'b01, 2'b00, 2'b00, 0, 0));
        nc(); bus.opcode = OPC_BRANCH; #1;
        chk_out("ld_next_fetch", V_FETCH_ACK);
        chk_cnt("ld_instret", 4'd2);

        // ---- BRANCH taken, then not taken ----
        nc(); #1; chk_out("br1_decode", V_DECODE);
        nc(); bus.branch_taken = 1'b1; #1;
        chk_out("br1_execute", ev(3'd3, 0,0,0, 0,1, 2'b01, 0, 2'b00, 2'b01, 2'b00, 0, 0));
        nc(); bus.branch_taken = 1'b0; #1;
        chk_out("br2_fetch", V_FETCH_ACK);
        chk_cnt("br1_instret", 4'd3);
        nc(); #1; chk_out("br2_decode", V_DECODE);
        nc(); #1;
        chk_out("br2_execute", ev(3'd3, 0,0,0, 0,0, 2'b01, 0, 2'b00, 2'b01, 2'b00, 0, 0));
        nc(); bus.opcode = OPC_JAL; #1;
        chk_out("jal_fetch", V_FETCH_ACK);
        chk_cnt("br2_instret", 4'd4);

        // ---- JAL ----
        nc(); #1; chk_out("jal_decode", V_DECODE);
        nc(); #1; chk_out("jal_execute", ev(3'd3, 0,0,0, 0,1, 2'b01, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        nc(); #1; chk_out("jal_wb", ev(3'd5, 0,0,0, 0,0, 2'b00, 1, 2'b10, 2'b00, 2'b00, 0, 0));

        // ---- STORE, with one FETCH wait cycle ----
        nc(); bus.opcode = OPC_STORE; bus.mem_ack = 1'b0; #1;
        chk_out("st_fetch_wait", V_FETCH_WAIT);
        chk_cnt("jal_instret", 4'd5);
        nc(); bus.mem_ack = 1'b1; #1;
        chk_out("st_fetch", V_FETCH_ACK);
        nc(); #1; chk_out("st_decode", V_DECODE);
        nc(); #1; chk_out("st_execute", ev(3'd3, 0,0,0, 0,0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 1, 0));
        nc(); #1; chk_out("st_mem", ev(3'd4, 1,1,1, 0,0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        nc(); bus.opcode = OPC_BRANCH; #1;
        chk_out("st_next_fetch", V_FETCH_ACK);
        chk_cnt("st_instret", 4'd6);

        // ---- ten 3-cycle branches: 6 + 10 = 16 retires wraps a 4-bit count ----
        repeat (30) nc();
        #1;
        chk_out("wrap_fetch", V_FETCH_ACK);
        chk_cnt("wrap_instret", 4'd0);

        // ---- Illegal opcode ----
        bus.opcode = OPC_ILL;
        nc(); #1; chk_out("ill_decode", V_DECODE);
        nc(); #1; chk_out("ill_halt", V_HALT);
        for (int i = 0; i < 10; i++) begin
            nc(); bus.mem_ack = i[0]; #1;
            chk_out("ill_halt_hold", V_HALT);
        end
        nreset = 1'b0; #1;
        chk_out("ill_reset", V_IDLE);
        chk_cnt("ill_reset_instret", 4'd0);

        // ---- Reset during a FETCH wait ----
        bus.opcode = OPC_OP; bus.mem_ack = 1'b0;
        nc(); nreset = 1'b1; #1;
        chk_out("rw_idle", V_IDLE);
        nc(); #1; chk_out("rw_fetch_wait1", V_FETCH_WAIT);
        nc(); #1; chk_out("rw_fetch_wait2", V_FETCH_WAIT);
        bus.mem_ack = 1'b1; #1;
        chk_out("rw_fetch_ack", V_FETCH_ACK);
        nreset = 1'b0; #1;
        chk_out("rw_abort", V_IDLE);
        chk_cnt("rw_instret", 4'd0);
        nc(); nreset = 1'b1; #1;
        chk_out("rw_idle_again", V_IDLE);
        nc(); #1; chk_out("rw_fetch_again", V_FETCH_ACK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle FSM that sequences the RV32I datapath: fetch, decode, execute, memory, write-back. It drives the ALU operation class and operand selects, the PC/IR/register-file write enables and the shared instruction/data memory handshake, and counts retired instructions. It sits beside the combinational ALU decoder. That decoder refines `alu_op` with funct3/funct7, so this block never looks at funct fields.

## Interface
- `INSTRET_WIDTH`, default 32: width of the retired-instruction counter.
- `clk` input, 1: single clock, rising edge.
- `nreset` input, 1: asynchronous active-low reset.
- `opcode` input, 7: IR[6:0]. The IR is held stable from DECODE until the next FETCH.
- `branch_taken` input, 1: ALU compare result, valid in EXECUTE for BRANCH.
- `mem_ack` input, 1: memory completion. It may be high in the same cycle as `mem_req` (zero-wait).
- `mem_req` output, 1: memory access request.
- `mem_we` output, 1: 1 = store.
- `addr_sel` output, 1: 0 = PC, 1 = ALUOut register.
- `ir_we` output, 1: IR load.
- `pc_we` output, 1: PC load.
- `pc_sel` output, 2: 00 = PC+4, 01 = ALUOut register, 10 = live ALU result.
- `reg_we` output, 1: register-file write.
- `wb_sel` output, 2: 00 = ALUOut, 01 = memory data, 10 = old PC+4.
- `alu_op` output, 2: 00 = add, 01 = branch compare, 10 = funct-decoded.
- `alu_src_a` output, 2: 00 = rs1, 01 = old PC, 10 = zero.
- `alu_src_b` output, 1: 0 = rs2, 1 = immediate.
- `state` output, 3: current state, for debug.
- `halted` output, 1: illegal opcode seen.
- `instret` output, INSTRET_WIDTH: retired-instruction count.

## Operation
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, HALT=7. Codes 6 and any other unused code go to IDLE.
- All outputs are combinational from state, `opcode`, `mem_ack` and `branch_taken`. Every output not listed for a state is 0.
- IDLE:
  - Outputs all 0.
  - Next state is FETCH, unconditionally.
- FETCH:
  - `mem_req`=1, `addr_sel`=0.
  - When `mem_ack`=1: `ir_we`=1, `pc_we`=1, `pc_sel`=00, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Speculative branch/JAL target: `alu_op`=00, `alu_src_a`=01, `alu_src_b`=1.
  - Known opcodes (LOAD 0000011, STORE 0100011, OP 0110011, OP-IMM 0010011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111) go to EXECUTE.
  - Any other opcode goes to HALT.
- EXECUTE, by opcode:
  - OP: `alu_op`=10, `alu_src_b`=0; go to WB.
  - OP-IMM: `alu_op`=10, `alu_src_b`=1; go to WB.
  - LOAD/STORE: `alu_op`=00, `alu_src_b`=1; go to MEM.
  - BRANCH: `alu_op`=01, `alu_src_b`=0, `pc_we`=`branch_taken`, `pc_sel`=01; go to FETCH and retire.
  - JAL: `pc_we`=1, `pc_sel`=01; go to WB.
  - JALR: `alu_op`=00, `alu_src_b`=1, `pc_we`=1, `pc_sel`=10; go to WB.
  - LUI: `alu_src_a`=10, `alu_src_b`=1, `alu_op`=00; go to WB.
  - AUIPC: `alu_src_a`=01, `alu_src_b`=1, `alu_op`=00; go to WB.
- MEM:
  - `mem_req`=1, `addr_sel`=1, `mem_we`=(opcode==STORE).
  - On `mem_ack`: LOAD goes to WB; STORE goes to FETCH and retires.
  - Without `mem_ack`, hold in MEM.
- WB:
  - `reg_we`=1.
  - `wb_sel`=01 for LOAD, 10 for JAL/JALR, 00 otherwise.
  - Go to FETCH and retire.
- HALT:
  - `halted`=1; all other outputs 0.
  - Stays in HALT until reset. `mem_ack` is ignored.
- `instret` increments by 1 on each retire edge and wraps from all-ones to 0.
- `mem_ack` is ignored in every state except FETCH and MEM.

## Timing
- Reset values: state=IDLE, `instret`=0, `halted`=0. Every other output is 0 while in IDLE.
- Asserting `nreset` mid-instruction (including during a pending memory request) aborts immediately. No write enable may glitch high after reset assertion.
- First `mem_req` is in the second cycle after `nreset` deasserts. IDLE occupies the first cycle.
- Zero-wait cycles per instruction, counted from the FETCH cycle to the next FETCH:
  - OP/OP-IMM/LUI/AUIPC/JAL/JALR/STORE: 4 cycles.
  - LOAD: 5 cycles.
  - BRANCH: 3 cycles.
- Each memory wait cycle adds 1 cycle in FETCH or MEM.
- `ir_we`, `pc_we` and `reg_we` are single-cycle pulses. At most one PC write per instruction, except JAL/JALR and taken BRANCH: these have the FETCH PC+4 write and then exactly one more PC write in EXECUTE.
- `instret` updates on the clock edge that leaves the retiring state. It is visible in the following cycle.

## Test plan
- **Reset then R-type, zero-wait.** Release reset, `mem_ack`=1 constantly, `opcode`=0110011.
  - `state` sequence: 0,1,2,3,5,1.
  - `alu_op`=10 in EXECUTE; `reg_we` high only in WB.
  - `instret`=1 after WB.
- **LOAD with 2 wait cycles in MEM.** `mem_ack`=0 for two MEM cycles.
  - `mem_req`=1, `addr_sel`=1 and `mem_we`=0 held for 3 MEM cycles.
  - WB has `wb_sel`=01.
  - Total 7 cycles.
- **BRANCH.** `branch_taken`=1 then 0 on two consecutive branches.
  - First branch: `pc_we`=1, `pc_sel`=01 in EXECUTE.
  - Second branch: no `pc_we` in EXECUTE.
  - Both take 3 cycles; `instret` increments by 2.
- **JAL and STORE.**
  - JAL: `pc_we` in FETCH and in EXECUTE, then WB with `wb_sel`=10.
  - STORE: MEM with `mem_we`=1, then straight to FETCH with no `reg_we`.
- **Illegal opcode 0000000.**
  - DECODE goes to HALT (state=7, `halted`=1).
  - `mem_req` stays 0 for 10 cycles despite `mem_ack` toggling.
  - Reset returns to IDLE with `halted`=0.
- **Reset asserted during a FETCH wait.**
  - All outputs drop in the same cycle; `instret`=0.
  - Counter wrap: with INSTRET_WIDTH=4, 16 retires return `instret` to 0.
